// File: rtl/dmac_xfer_seq.sv
// DMAC transfer sequencer: runs one block of word cycles for the granted channel and writes back MADR/BA.
// Optional build macro DMAC_STEP_BACK_EN adds the address-decrement mode selected by CFG_STEP_IN.
module dmac_xfer_seq #(
  parameter int NUM_CH = 7,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_ASYNC,
  input  logic              RST_SYNC,
  input  logic              EN,
  input  logic [NUM_CH-1:0] DMAC_CH_SEL_IN,
  input  logic [ADDR_W-1:0] CFG_MADR_IN,
  input  logic [CNT_W-1:0]  CFG_BS_IN,
  input  logic [CNT_W-1:0]  CFG_BA_IN,
  input  logic              CFG_WR_IN,
  input  logic              CFG_STEP_IN,
  output logic              BUS_CYC_OUT,
  output logic              BUS_STB_OUT,
  output logic              BUS_WE_OUT,
  output logic [ADDR_W-1:0] BUS_ADR_OUT,
  input  logic              BUS_ACK_IN,
  output logic              BUS_LAST_ACK_OUT,
  output logic [NUM_CH-1:0] DMAC_ACK_OUT,
  output logic [ADDR_W-1:0] WB_MADR_OUT,
  output logic [CNT_W-1:0]  WB_BA_OUT,
  output logic [NUM_CH-1:0] WB_VLD_OUT,
  output logic [NUM_CH-1:0] DONE_OUT,
  output logic              BUSY_OUT
);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, WBACK} state_t;

  state_t            state;
  logic [NUM_CH-1:0] ch;
  logic [ADDR_W-1:0] adr;
  logic [CNT_W:0]    wcnt;
  logic [CNT_W-1:0]  ba;
  logic              cyc;
  logic              we;
  logic [ADDR_W-1:0] wb_madr;
  logic [CNT_W-1:0]  wb_ba;
  logic [NUM_CH-1:0] wb_vld;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] sel_low;
  logic [ADDR_W-1:0] adr_next;
  logic              word_ack;
  logic              last_ack;

  // Two's-complement trick isolates the lowest set grant bit.
  assign sel_low = DMAC_CH_SEL_IN & (~DMAC_CH_SEL_IN + NUM_CH'(1));

`ifdef DMAC_STEP_BACK_EN
  logic step_back;
  assign adr_next = step_back ? (adr - ADDR_W'(4)) : (adr + ADDR_W'(4));
`else
  logic unused_step;
  assign unused_step = CFG_STEP_IN;
  assign adr_next    = adr + ADDR_W'(4);
`endif

  // Bus ACK only counts inside XFER and in enabled cycles.
  assign word_ack = EN && BUS_ACK_IN && (state == XFER);
  assign last_ack = word_ack && (wcnt == (CNT_W+1)'(1));

  assign BUS_LAST_ACK_OUT = last_ack;
  assign DMAC_ACK_OUT     = ch & {NUM_CH{word_ack}};
  assign BUS_CYC_OUT      = cyc;
  assign BUS_STB_OUT      = cyc;
  assign BUS_WE_OUT       = we;
  assign BUS_ADR_OUT      = adr;
  assign WB_MADR_OUT      = wb_madr;
  assign WB_BA_OUT        = wb_ba;
  assign WB_VLD_OUT       = wb_vld;
  assign DONE_OUT         = done;
  assign BUSY_OUT         = (state != IDLE);

  always_ff @(posedge CLK or posedge RST_ASYNC) begin
    if (RST_ASYNC) begin
      state   <= IDLE;
      ch      <= '0;
      adr     <= '0;
      wcnt    <= '0;
      ba      <= '0;
      cyc     <= 1'b0;
      we      <= 1'b0;
      wb_madr <= '0;
      wb_ba   <= '0;
      wb_vld  <= '0;
      done    <= '0;
`ifdef DMAC_STEP_BACK_EN
      step_back <= 1'b0;
`endif
    end else if (RST_SYNC) begin
      state   <= IDLE;
      ch      <= '0;
      adr     <= '0;
      wcnt    <= '0;
      ba      <= '0;
      cyc     <= 1'b0;
      we      <= 1'b0;
      wb_madr <= '0;
      wb_ba   <= '0;
      wb_vld  <= '0;
      done    <= '0;
`ifdef DMAC_STEP_BACK_EN
      step_back <= 1'b0;
`endif
    end else if (EN) begin
      wb_vld <= '0;
      done   <= '0;
      case (state)
        IDLE: begin
          if (|DMAC_CH_SEL_IN) begin
            ch    <= sel_low;
            state <= LOAD;
          end
        end
        LOAD: begin
          adr  <= CFG_MADR_IN;
          wcnt <= (CFG_BS_IN == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, CFG_BS_IN};
          ba   <= CFG_BA_IN;
          we   <= CFG_WR_IN;
`ifdef DMAC_STEP_BACK_EN
          step_back <= CFG_STEP_IN;
`endif
          if (CFG_BA_IN == '0) begin
            state   <= WBACK;
            wb_vld  <= ch;
            done    <= ch;
            wb_madr <= CFG_MADR_IN;
            wb_ba   <= '0;
          end else begin
            state <= XFER;
            cyc   <= 1'b1;
          end
        end
        XFER: begin
          if (word_ack) begin
            adr  <= adr_next;
            wcnt <= wcnt - (CNT_W+1)'(1);
            if (last_ack) begin
              cyc     <= 1'b0;
              ba      <= ba - CNT_W'(1);
              state   <= WBACK;
              wb_vld  <= ch;
              wb_madr <= adr_next;
              wb_ba   <= ba - CNT_W'(1);
              if (ba == CNT_W'(1)) done <= ch;
            end
          end
        end
        WBACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_xfer_seq.sv
// Self-checking bench for dmac_xfer_seq: directed scenarios plus randomized blocks against a
// per-block reference computed from address arithmetic and a per-channel register model.
module tb_dmac_xfer_seq;
  localparam int NUM_CH = 7;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;
`ifdef DMAC_STEP_BACK_EN
  localparam bit STEP_BUILT = 1'b1;
`else
  localparam bit STEP_BUILT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_async, rst_sync, en;
  logic [NUM_CH-1:0] sel_in;
  logic [ADDR_W-1:0] madr_in;
  logic [CNT_W-1:0]  bs_in, ba_in;
  logic              wr_in, step_in, ack;
  logic              cyc, stb, we, last_ack, busy;
  logic [ADDR_W-1:0] adr, wb_madr;
  logic [CNT_W-1:0]  wb_ba;
  logic [NUM_CH-1:0] dmac_ack, wb_vld, done;

  int total = 0;
  int bad   = 0;

  logic [31:0] ch_madr [NUM_CH];
  logic [15:0] ch_ba   [NUM_CH];

  dmac_xfer_seq #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST_ASYNC(rst_async), .RST_SYNC(rst_sync), .EN(en),
    .DMAC_CH_SEL_IN(sel_in), .CFG_MADR_IN(madr_in), .CFG_BS_IN(bs_in), .CFG_BA_IN(ba_in),
    .CFG_WR_IN(wr_in), .CFG_STEP_IN(step_in),
    .BUS_CYC_OUT(cyc), .BUS_STB_OUT(stb), .BUS_WE_OUT(we), .BUS_ADR_OUT(adr),
    .BUS_ACK_IN(ack), .BUS_LAST_ACK_OUT(last_ack), .DMAC_ACK_OUT(dmac_ack),
    .WB_MADR_OUT(wb_madr), .WB_BA_OUT(wb_ba), .WB_VLD_OUT(wb_vld), .DONE_OUT(done),
    .BUSY_OUT(busy)
  );

  always #5 clk = ~clk;

  // Runs one grant -> block -> write-back round and checks it against the arithmetic model.
  task automatic do_block(input logic [6:0] sel, input logic [6:0] sel_mid,
                          input logic [31:0] madr, input logic [15:0] bs, input logic [15:0] ba,
                          input logic wr, input logic step, input int ack_pct, input int en_pct,
                          input logic [31:0] en_low_mask,
                          output logic [31:0] nxt_madr, output logic [15:0] nxt_ba);
    int ch, words, sent, cycles;
    logic [6:0] oh, exp_done;
    logic dec, a, e;
    logic [31:0] exp_adr;
    ch = -1;
    for (int i = 0; i < NUM_CH; i++) if (sel[i] && ch < 0) ch = i;
    oh = '0;
    oh[ch] = 1'b1;
    words = (bs == 16'd0) ? 65536 : int'(bs);
    dec = step && STEP_BUILT;
    if (ba == 16'd0) begin
      nxt_madr = madr;
      nxt_ba   = 16'd0;
    end else begin
      nxt_madr = dec ? madr - 32'(4 * words) : madr + 32'(4 * words);
      nxt_ba   = ba - 16'd1;
    end
    exp_done = (nxt_ba == 16'd0) ? oh : 7'b0;

    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
    sel_in = sel; madr_in = madr; bs_in = bs; ba_in = ba; wr_in = wr; step_in = step;
    ack = 1'b0; en = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, cyc, stb} !== 3'b100) begin
      bad++; $display("FAIL load_state busy/cyc/stb got=%b exp=100", {busy, cyc, stb});
    end
    sel_in = sel_mid;
    ack = 1'($urandom_range(0, 1));
    #1;
    total++;
    if ({dmac_ack, last_ack} !== 8'h00) begin
      bad++; $display("FAIL load_ack got=%h exp=00", {dmac_ack, last_ack});
    end
    @(negedge clk);
    if (ba != 16'd0) begin
      sent = 0; cycles = 0;
      while (sent < words && cycles < 200) begin
        exp_adr = dec ? madr - 32'(4 * sent) : madr + 32'(4 * sent);
        total++;
        if ({cyc, stb, we} !== {2'b11, wr}) begin
          bad++; $display("FAIL xfer_ctl cyc/stb/we got=%b exp=%b", {cyc, stb, we}, {2'b11, wr});
        end
        total++;
        if (adr !== exp_adr) begin
          bad++; $display("FAIL xfer_adr word=%0d got=%h exp=%h", sent, adr, exp_adr);
        end
        a = ($urandom_range(0, 99) < ack_pct);
        e = ($urandom_range(0, 99) >= en_pct) && !(cycles < 32 && en_low_mask[cycles]);
        ack = a; en = e;
        #1;
        if (e) begin
          total++;
          if (last_ack !== (a && sent == words - 1)) begin
            bad++; $display("FAIL last_ack word=%0d got=%b exp=%b", sent, last_ack, a && sent == words - 1);
          end
          total++;
          if (dmac_ack !== (a ? oh : 7'b0)) begin
            bad++; $display("FAIL dmac_ack got=%b exp=%b", dmac_ack, a ? oh : 7'b0);
          end
        end
        if (a && e) sent++;
        @(negedge clk);
        cycles++;
      end
      ack = 1'b0; en = 1'b1;
      total++;
      if (sent != words) begin bad++; $display("FAIL xfer_timeout words got=%0d exp=%0d", sent, words); end
    end
    total++;
    if ({busy, cyc} !== 2'b10) begin bad++; $display("FAIL wback_state busy/cyc got=%b exp=10", {busy, cyc}); end
    total++;
    if (wb_vld !== oh) begin bad++; $display("FAIL wb_vld got=%b exp=%b", wb_vld, oh); end
    total++;
    if (wb_madr !== nxt_madr) begin bad++; $display("FAIL wb_madr got=%h exp=%h", wb_madr, nxt_madr); end
    total++;
    if (wb_ba !== nxt_ba) begin bad++; $display("FAIL wb_ba got=%0d exp=%0d", wb_ba, nxt_ba); end
    total++;
    if (done !== exp_done) begin bad++; $display("FAIL done got=%b exp=%b", done, exp_done); end
    sel_in = '0;
    ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    ack = 1'b0;
    total++;
    if ({busy, cyc, wb_vld, done} !== 16'h0) begin
      bad++; $display("FAIL post_wback busy/cyc/vld/done got=%h exp=0", {busy, cyc, wb_vld, done});
    end
  endtask

  task automatic test_reset();
    rst_async = 1'b1; rst_sync = 1'b0; en = 1'b1; sel_in = '0; madr_in = '0; bs_in = '0;
    ba_in = '0; wr_in = 1'b0; step_in = 1'b0; ack = 1'b0;
    #2;
    total++;
    if ({cyc, stb, we, busy, last_ack, dmac_ack, wb_vld, done} !== 26'h0) begin
      bad++; $display("FAIL reset_ctl got=%h exp=0", {cyc, stb, we, busy, last_ack, dmac_ack, wb_vld, done});
    end
    total++;
    if ({adr, wb_madr, wb_ba} !== 80'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {adr, wb_madr, wb_ba});
    end
    repeat (2) @(negedge clk);
    rst_async = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] m; logic [15:0] b;
    do_block(7'b0000001, 7'b0000001, 32'h1000, 16'd4, 16'd1, 1'b1, 1'b0, 100, 0, 32'h0, m, b);
  endtask

  task automatic test_multi_block();
    logic [31:0] m; logic [15:0] b;
    ch_madr[2] = 32'h0000_8000; ch_ba[2] = 16'd3;
    for (int r = 0; r < 3; r++) begin
      do_block(7'b0000100, 7'b0000100, ch_madr[2], 16'd2, ch_ba[2], 1'b0, 1'b0, 100, 0, 32'h0, m, b);
      ch_madr[2] = m; ch_ba[2] = b;
    end
  endtask

  task automatic test_ba_zero();
    logic [31:0] m; logic [15:0] b;
    do_block(7'b0010000, 7'b0010000, 32'h0000_4440, 16'd3, 16'd0, 1'b0, 1'b0, 100, 0, 32'h0, m, b);
  endtask

  task automatic test_sel_switch();
    logic [31:0] m; logic [15:0] b;
    do_block(7'b0000100, 7'b0000001, 32'h0000_2000, 16'd3, 16'd2, 1'b1, 1'b0, 60, 0, 32'h0, m, b);
    do_block(7'b0000001, 7'b0000000, 32'h0000_3000, 16'd2, 16'd1, 1'b0, 1'b0, 100, 0, 32'h0, m, b);
  endtask

  task automatic test_non_onehot();
    logic [31:0] m; logic [15:0] b;
    do_block(7'b1101000, 7'b0000000, 32'h0000_5000, 16'd1, 16'd1, 1'b0, 1'b0, 100, 0, 32'h0, m, b);
  endtask

  task automatic test_step();
    logic [31:0] m; logic [15:0] b;
    do_block(7'b0000001, 7'b0000001, 32'h0000_0004, 16'd3, 16'd1, 1'b0, 1'b1, 100, 0, 32'h0, m, b);
  endtask

  task automatic test_en_freeze();
    logic [31:0] m; logic [15:0] b;
    do_block(7'b0000010, 7'b0000010, 32'h0000_6000, 16'd4, 16'd1, 1'b1, 1'b0, 100, 0, 32'h0000_000E, m, b);
  endtask

  task automatic test_sync_reset();
    @(negedge clk);
    sel_in = 7'b0000001; madr_in = 32'h3000; bs_in = 16'd4; ba_in = 16'd1; wr_in = 1'b0; step_in = 1'b0;
    @(negedge clk);
    sel_in = '0;
    @(negedge clk);
    ack = 1'b1;
    repeat (2) @(negedge clk);
    ack = 1'b0;
    total++;
    if ({cyc, adr} !== {1'b1, 32'h3008}) begin
      bad++; $display("FAIL sreset_pre cyc/adr got=%h exp=%h", {cyc, adr}, {1'b1, 32'h3008});
    end
    rst_sync = 1'b1;
    @(negedge clk);
    total++;
    if ({cyc, stb, busy, wb_vld, done, adr} !== 49'h0) begin
      bad++; $display("FAIL sreset_abort got=%h exp=0", {cyc, stb, busy, wb_vld, done, adr});
    end
    rst_sync = 1'b0;
    @(negedge clk);
    total++;
    if ({cyc, busy, wb_vld, done} !== 16'h0) begin
      bad++; $display("FAIL sreset_after got=%h exp=0", {cyc, busy, wb_vld, done});
    end
  endtask

  task automatic test_random();
    logic [31:0] m, base; logic [15:0] b, bs; logic [6:0] sel, selm;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_madr[i] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (i == 3) ch_madr[i] = 32'hFFFF_FFF0;
      ch_ba[i] = 16'($urandom_range(0, 3));
    end
    for (int n = 0; n < 24; n++) begin
      sel = 7'($urandom_range(1, 127));
      selm = 7'($urandom_range(0, 127));
      bs = 16'($urandom_range(1, 5));
      base = 32'h0;
      for (int i = NUM_CH - 1; i >= 0; i--) if (sel[i]) base = 32'(i);
      do_block(sel, selm, ch_madr[base], bs, ch_ba[base], 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(30, 100), $urandom_range(0, 30), 32'h0, m, b);
      ch_madr[base] = m;
      ch_ba[base] = (b == 16'd0) ? 16'($urandom_range(0, 3)) : b;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_block();
    test_ba_zero();
    test_sel_switch();
    test_non_onehot();
    test_step();
    test_en_freeze();
    test_sync_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
